// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - state encoding and parity-mode constants shared by the frame parity unit
package parity_pkg;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Parity bit to transmit so that data ones plus this bit match the requested sense.
   function automatic logic frame_parity(input logic data_xor, input logic mode);
      return data_xor ^ mode;
   endfunction

endpackage

// File: rtl/parity_frame_unit_if.sv
// rtl/parity_frame_unit_if.sv - word-in / result-out handshake bundle of the frame parity unit
interface parity_frame_unit_if #(
   parameter int DATA_W    = 8,
   parameter int MAX_WORDS = 16
);
   localparam int WORDS_W = $clog2(MAX_WORDS + 1);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              in_par;

   logic               out_valid;
   logic               out_ready;
   logic               out_par;
   logic               out_err;
   logic [WORDS_W-1:0] out_words;

   modport master (
      output in_valid, in_data, in_last, in_par, out_ready,
      input  in_ready, out_valid, out_par, out_err, out_words
   );

   modport slave (
      input  in_valid, in_data, in_last, in_par, out_ready,
      output in_ready, out_valid, out_par, out_err, out_words
   );

endinterface

// File: rtl/parity_word_reduce.sv
// rtl/parity_word_reduce.sv - combinational XOR reduction of one data word
module parity_word_reduce #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] data_i,
   output logic              par_o
);

   assign par_o = ^data_i;

endmodule

// File: rtl/parity_frame_unit.sv
// rtl/parity_frame_unit.sv - frame-level parity generator/checker with valid/ready in and out
// Build option: PARITY_ERR_CNT_EN adds the saturating err_cnt output.
module parity_frame_unit
   import parity_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MAX_WORDS = 16,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             odd_mode,
`ifdef PARITY_ERR_CNT_EN
   output logic [CNT_W-1:0] err_cnt,
`endif
   parity_frame_unit_if.slave bus
);

   localparam int WORDS_W = $clog2(MAX_WORDS + 1);
   localparam logic [WORDS_W-1:0] LAST_IDX = WORDS_W'(MAX_WORDS - 1);

   state_e             state_q;
   logic               acc_q;
   logic               mode_q;
   logic               par_q;
   logic               err_q;
   logic [WORDS_W-1:0] count_q;
   logic [WORDS_W-1:0] words_q;

   logic               word_par;
   logic               accept;
   logic               handoff;
   logic               truncate;
   logic               close;
   logic               acc_d;
   logic               mode_d;
   logic               par_d;
   logic               err_d;
   logic [WORDS_W-1:0] count_d;

   parity_word_reduce #(.DATA_W(DATA_W)) u_reduce (
      .data_i (bus.in_data),
      .par_o  (word_par)
   );

   assign bus.in_ready  = (state_q == ST_ACCUM) && !rst;
   assign bus.out_valid = (state_q == ST_HOLD);
   assign bus.out_par   = par_q;
   assign bus.out_err   = err_q;
   assign bus.out_words = words_q;

   always_comb begin
      accept   = bus.in_valid && bus.in_ready;
      handoff  = bus.out_valid && bus.out_ready;
      mode_d   = (count_q == '0) ? odd_mode : mode_q;
      acc_d    = acc_q ^ word_par;
      count_d  = count_q + WORDS_W'(1);
      // A full frame without in_last is closed here and always reported as errored.
      truncate = !bus.in_last && (count_q == LAST_IDX);
      close    = accept && (bus.in_last || truncate);
      par_d    = frame_parity(acc_d, mode_d);
      err_d    = truncate || (bus.in_par != par_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACCUM;
         acc_q   <= 1'b0;
         count_q <= '0;
         mode_q  <= PAR_EVEN;
         par_q   <= 1'b0;
         err_q   <= 1'b0;
         words_q <= '0;
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (accept) begin
                  acc_q   <= acc_d;
                  count_q <= count_d;
                  mode_q  <= mode_d;
                  if (close) begin
                     state_q <= ST_HOLD;
                     par_q   <= par_d;
                     err_q   <= err_d;
                     words_q <= count_d;
                  end
               end
            end
            ST_HOLD: begin
               if (handoff) begin
                  state_q <= ST_ACCUM;
                  acc_q   <= 1'b0;
                  count_q <= '0;
               end
            end
            default: state_q <= ST_ACCUM;
         endcase
      end
   end

`ifdef PARITY_ERR_CNT_EN
   logic [CNT_W-1:0] err_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else if (handoff && err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
         err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
   end

   assign err_cnt = err_cnt_q;
`endif

`ifndef SYNTHESIS
   hold_outputs_stable: assert property (@(posedge clk) disable iff (rst)
      (bus.out_valid && !bus.out_ready) |=>
         (bus.out_valid && $stable({bus.out_par, bus.out_err, bus.out_words})));

   no_accept_with_handoff: assert property (@(posedge clk) disable iff (rst)
      !(accept && handoff));
`endif

endmodule

// File: tb/tb_parity_frame_unit.sv
// tb/tb_parity_frame_unit.sv - scoreboard bench for parity_frame_unit against a frame-level reference model
module tb_parity_frame_unit;

   localparam int DATA_W    = 8;
   localparam int MAX_WORDS = 4;
   localparam int CNT_W     = 2;
   localparam int WORDS_W   = $clog2(MAX_WORDS + 1);
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   typedef struct {
      logic par;
      logic err;
      int   words;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   logic odd_mode;

   always #5 clk = ~clk;

   parity_frame_unit_if #(.DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS)) bus ();

`ifdef PARITY_ERR_CNT_EN
   logic [CNT_W-1:0] err_cnt;
`endif

   parity_frame_unit #(
      .DATA_W    (DATA_W),
      .MAX_WORDS (MAX_WORDS),
      .CNT_W     (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .odd_mode (odd_mode),
`ifdef PARITY_ERR_CNT_EN
      .err_cnt  (err_cnt),
`endif
      .bus      (bus)
   );

   logic [DATA_W-1:0] ref_word;
   logic              ref_word_par;

   parity_word_reduce #(.DATA_W(DATA_W)) u_ref_reduce (
      .data_i (ref_word),
      .par_o  (ref_word_par)
   );

   int   checks   = 0;
   int   failures = 0;
   int   rdy_mode = 1;
   res_t exp_q[$];
   int   m_count  = 0;
   int   m_ones   = 0;
   logic m_mode   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: count data ones over the whole frame, decide closure from the frame rules.
   task automatic model_accept(input logic [DATA_W-1:0] d, input logic last, input logic p,
                               output bit closed);
      res_t r;
      if (m_count == 0) m_mode = odd_mode;
      m_count++;
      m_ones += $countones(d);
      closed = last || (m_count == MAX_WORDS);
      if (closed) begin
         r.par   = ((m_ones % 2) == 1) ^ m_mode;
         r.err   = (!last) ? 1'b1 : (p != r.par);
         r.words = m_count;
         exp_q.push_back(r);
         m_count = 0;
         m_ones  = 0;
      end
   endtask

   task automatic send_word(input logic [DATA_W-1:0] d, input logic last, input logic p,
                            output bit closed, output int cycles);
      bit acc;
      acc    = 0;
      closed = 0;
      cycles = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      bus.in_par   = p;
      while (!acc) begin
         @(negedge clk);
         acc = bus.in_ready;
         if (acc) model_accept(d, last, p, closed);
         @(posedge clk);
         #1;
         cycles++;
         if (!acc && cycles >= 200) begin
            check("accept_timeout", 0, 1);
            break;
         end
      end
      bus.in_valid = 1'b0;
      if (closed) begin
         #2;
         check("latency_out_valid", bus.out_valid, 1);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      rdy_mode = 1;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      m_count = 0;
      m_ones  = 0;
      exp_q.delete();
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_par", bus.out_par, 0);
      check("rst_out_err", bus.out_err, 0);
      check("rst_out_words", bus.out_words, 0);
`ifdef PARITY_ERR_CNT_EN
      check("rst_err_cnt", err_cnt, 0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", bus.in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin : ready_driver
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 1)      bus.out_ready = 1'b1;
         else if (rdy_mode == 2) bus.out_ready = 1'b0;
         else                    bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin : monitor
      res_t               r;
      logic               held;
      logic [WORDS_W+1:0] snap;
      int                 m_cnt;
      held  = 1'b0;
      snap  = '0;
      m_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            held  = 1'b0;
            m_cnt = 0;
         end else begin
`ifdef PARITY_ERR_CNT_EN
            check("err_cnt_track", 32'(err_cnt), 32'(m_cnt));
`endif
            if (bus.out_valid) begin
               if (held)
                  check("hold_stable", 32'({bus.out_par, bus.out_err, bus.out_words}), 32'(snap));
               snap = {bus.out_par, bus.out_err, bus.out_words};
               held = 1'b1;
               if (bus.out_ready) begin
                  held = 1'b0;
                  if (exp_q.size() == 0) begin
                     check("unexpected_result", 1, 0);
                  end else begin
                     r = exp_q.pop_front();
                     check("out_par", bus.out_par, r.par);
                     check("out_err", bus.out_err, r.err);
                     check("out_words", 32'(bus.out_words), 32'(r.words));
                     if (r.err && m_cnt < CNT_MAX) m_cnt++;
                  end
               end
            end else begin
               held = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bit closed;
      int n;
`ifdef PARITY_ERR_CNT_EN
      int cnt_seq[5] = '{1, 2, 3, 3, 3};
`endif
      rst          = 1'b1;
      odd_mode     = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      bus.in_par   = 1'b0;
      ref_word     = '0;

      for (int i = 0; i < 4; i++) begin
         ref_word = DATA_W'($urandom);
         #1;
         check("word_reduce", ref_word_par, ($countones(ref_word) % 2) == 1);
      end

      do_reset();

      // Even mode, single word.
      drain();
      odd_mode = 1'b0;
      send_word(8'h04, 1'b1, 1'b1, closed, n);
      check("t1_par", bus.out_par, 1);
      check("t1_err", bus.out_err, 0);
      check("t1_words", 32'(bus.out_words), 1);

      // Odd mode latched on first word; mid-frame change ignored.
      drain();
      odd_mode = 1'b1;
      send_word(8'h2B, 1'b0, 1'b0, closed, n);
      odd_mode = 1'b0;
      send_word(8'h00, 1'b0, 1'b0, closed, n);
      send_word(8'hFF, 1'b1, 1'b0, closed, n);
      check("t2_par", bus.out_par, 1);
      check("t2_err", bus.out_err, 1);
      check("t2_words", 32'(bus.out_words), 3);

      // Truncation at MAX_WORDS, then a fresh frame.
      drain();
      for (int i = 0; i < MAX_WORDS; i++) send_word(8'h01, 1'b0, 1'b0, closed, n);
      check("t3_closed", closed, 1);
      check("t3_err", bus.out_err, 1);
      check("t3_words", 32'(bus.out_words), MAX_WORDS);
      send_word(8'h03, 1'b1, 1'b0, closed, n);
      check("t3b_par", bus.out_par, 0);
      check("t3b_err", bus.out_err, 0);
      check("t3b_words", 32'(bus.out_words), 1);

      // Backpressure for five cycles, then handoff and immediate next word.
      drain();
      rdy_mode = 2;
      send_word(8'h81, 1'b0, 1'b0, closed, n);
      send_word(8'h10, 1'b1, 1'b1, closed, n);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_out_valid", bus.out_valid, 1);
      end
      rdy_mode = 1;
      @(posedge clk);
      #2;
      send_word(8'h00, 1'b1, 1'b0, closed, n);
      check("bp_next_accept_cycles", n, 2);

      // Reset mid-frame, then a clean single-word frame.
      drain();
      send_word(8'h11, 1'b0, 1'b0, closed, n);
      send_word(8'h22, 1'b0, 1'b0, closed, n);
      do_reset();
      odd_mode = 1'b0;
      send_word(8'h00, 1'b1, 1'b0, closed, n);
      check("t5_par", bus.out_par, 0);
      check("t5_err", bus.out_err, 0);
      check("t5_words", 32'(bus.out_words), 1);

      // Reset while a result is pending.
      drain();
      rdy_mode = 2;
      send_word(8'h07, 1'b1, 1'b0, closed, n);
      do_reset();
      rdy_mode = 1;

`ifdef PARITY_ERR_CNT_EN
      do_reset();
      odd_mode = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send_word(8'h01, 1'b1, 1'b0, closed, n);
         @(posedge clk);
         #1;
         @(negedge clk);
         check("err_cnt_seq", 32'(err_cnt), 32'(cnt_seq[i]));
         @(posedge clk);
         #1;
      end
`endif

      // Randomized frames with random backpressure, gaps and mode toggling.
      drain();
      rdy_mode = 0;
      for (int f = 0; f < 40; f++) begin
         int len;
         len = $urandom_range(1, MAX_WORDS + 1);
         for (int w = 0; w < len; w++) begin
            odd_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk);
               #1;
            end
            send_word(DATA_W'($urandom), (w == len - 1), 1'($urandom_range(0, 1)), closed, n);
         end
      end

      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
